// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t StReq  = 2'd0;
  localparam fetch_state_t StWait = 2'd1;
  localparam fetch_state_t StHold = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register plus a one-entry hold buffer for a word that
// arrives while decode is stalled.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        stall,
  input  logic        wr_en,
  input  logic [31:0] wr_instr,
  input  logic [31:0] wr_pc4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc4
);

  // The hold buffer's valid bit doubles as its "full" flag.
  if_id_t entry_q, entry_d, hold_q, hold_d;

  always_comb begin
    entry_d = entry_q;
    hold_d  = hold_q;
    if (flush) begin
      entry_d.valid = 1'b0;
      hold_d.valid  = 1'b0;
    end else if (!stall) begin
      if (hold_q.valid) begin
        entry_d      = hold_q;
        hold_d.valid = 1'b0;
      end else if (wr_en) begin
        entry_d = '{valid: 1'b1, instr: wr_instr, pc4: wr_pc4};
      end else begin
        entry_d.valid = 1'b0;
      end
    end else if (wr_en) begin
      hold_d = '{valid: 1'b1, instr: wr_instr, pc4: wr_pc4};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
      hold_q  <= '0;
    end else begin
      entry_q <= entry_d;
      hold_q  <= hold_d;
    end
  end

  assign valid = entry_q.valid;
  assign instr = entry_q.instr;
  assign pc4   = entry_q.pc4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, request FSM and branch squash handling.
// Optional FETCH_PERF_CNT_EN adds fetch_count / squash_count outputs.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        br_take,
  input  logic [31:0] br_imm_ext,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [15:0] squash_count,
`endif
  output logic [15:0] if_id_imm16
);

  localparam logic [31:0] Step = 32'(WORD_BYTES);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d, sq_target_q, sq_target_d;
  logic         squash_q, squash_d;
  logic         req_en_q;
  logic         ack_v, drop, accept;
  logic [31:0]  br_target, pc_seq;

  assign br_target = if_id_pc4 + (br_imm_ext << 2);
  assign pc_seq    = pc_q + Step;

  // req_en_q keeps the request low for the first cycle after reset release.
  assign imem_req  = req_en_q && (state_q != StHold);
  assign imem_addr = pc_q;
  assign ack_v     = imem_req && imem_ack;
  assign drop      = ack_v && (squash_q || br_take);
  assign accept    = ack_v && !drop;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    squash_d    = squash_q;
    sq_target_d = sq_target_q;
    unique case (state_q)
      StReq, StWait: begin
        if (ack_v) begin
          squash_d = 1'b0;
          state_d  = (accept && id_stall) ? StHold : StReq;
          if (br_take) begin
            pc_d = br_target;
          end else if (squash_q) begin
            pc_d = sq_target_q;
          end else begin
            pc_d = pc_seq;
          end
        end else if (imem_req) begin
          // Request already on the bus: it must complete before redirecting.
          state_d = StWait;
          if (br_take) begin
            squash_d    = 1'b1;
            sq_target_d = br_target;
          end
        end
      end
      StHold: begin
        if (br_take) begin
          pc_d    = br_target;
          state_d = StReq;
        end else if (!id_stall) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StReq;
      pc_q        <= RESET_PC;
      squash_q    <= 1'b0;
      sq_target_q <= '0;
      req_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      squash_q    <= squash_d;
      sq_target_q <= sq_target_d;
      req_en_q    <= 1'b1;
    end
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (br_take),
    .stall    (id_stall),
    .wr_en    (accept),
    .wr_instr (imem_rdata),
    .wr_pc4   (pc_seq),
    .valid    (if_id_valid),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4)
  );

  assign if_id_imm16 = if_id_instr[15:0];

`ifdef FETCH_PERF_CNT_EN
  logic        loaded;
  logic [31:0] fetch_count_q;
  logic [15:0] squash_count_q;

  assign loaded = !br_take && !id_stall && ((state_q == StHold) || accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q  <= '0;
      squash_count_q <= '0;
    end else begin
      if (loaded) fetch_count_q <= fetch_count_q + 32'd1;
      if (drop)   squash_count_q <= squash_count_q + 16'd1;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign squash_count = squash_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_stall = 1'b0;
  logic        br_take = 1'b0;
  logic [31:0] br_imm_ext = '0;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [15:0] if_id_imm16;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] squash_count;
  logic [31:0] m_fetch_cnt;
  logic [15:0] m_squash_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_stall    (id_stall),
    .br_take     (br_take),
    .br_imm_ext  (br_imm_ext),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count (fetch_count),
    .squash_count(squash_count),
`endif
    .if_id_imm16 (if_id_imm16)
  );

  // Reference model: a fetch address, an optional pending redirect, an
  // optional parked word, and the decode-side record.
  logic        m_started, m_hold_full, m_valid, m_redirect;
  logic [31:0] m_pc, m_hold_instr, m_hold_pc4, m_instr, m_pc4, m_redirect_pc;

  task automatic model_reset();
    m_started = 0; m_hold_full = 0; m_valid = 0; m_redirect = 0;
    m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_hold_instr = 0; m_hold_pc4 = 0;
    m_redirect_pc = 0;
`ifdef FETCH_PERF_CNT_EN
    m_fetch_cnt = 0; m_squash_cnt = 0;
`endif
  endtask

  task automatic model_clock();
    logic req, acked, take;
    logic [31:0] tgt, old_pc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    req    = m_started && !m_hold_full;
    acked  = req && imem_ack;
    take   = acked && !m_redirect && !br_take;
    tgt    = m_pc4 + br_imm_ext * 4;
    old_pc = m_pc;
`ifdef FETCH_PERF_CNT_EN
    if (acked && !take) m_squash_cnt = m_squash_cnt + 1;
`endif
    if (acked) begin
      if (br_take) m_pc = tgt;
      else if (m_redirect) m_pc = m_redirect_pc;
      else m_pc = old_pc + 4;
      m_redirect = 0;
    end else if (req && br_take) begin
      m_redirect = 1; m_redirect_pc = tgt;
    end else if (m_hold_full && br_take) begin
      m_pc = tgt;
    end
    if (br_take) begin
      m_valid = 0; m_hold_full = 0;
    end else if (!id_stall) begin
      if (m_hold_full) begin
        m_valid = 1; m_instr = m_hold_instr; m_pc4 = m_hold_pc4; m_hold_full = 0;
      end else if (take) begin
        m_valid = 1; m_instr = imem_rdata; m_pc4 = old_pc + 4;
      end else begin
        m_valid = 0;
      end
`ifdef FETCH_PERF_CNT_EN
      if (m_valid) m_fetch_cnt = m_fetch_cnt + 1;
`endif
    end else if (take) begin
      m_hold_full = 1; m_hold_instr = imem_rdata; m_hold_pc4 = old_pc + 4;
    end
    m_started = 1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 0; imem_ack = 0; id_stall = 0; br_take = 0; br_imm_ext = 0; imem_rdata = 0;
    model_reset();
    cycle();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; imem_ack = 1; imem_rdata = 32'hFFFF_FFFF;
    model_reset();
    repeat (2) cycle();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
    n_cmp++; if (if_id_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", if_id_instr); end
    n_cmp++; if (if_id_pc4 !== 32'h0) begin n_bad++; $display("FAIL reset_pc4: got %h want 0", if_id_pc4); end
    rst_n = 1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL release_req_early: got %b want 0", imem_req); end
    cycle();
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL release_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL release_addr: got %h want 0", imem_addr); end
    imem_ack = 0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    imem_ack = 1; imem_rdata = 32'h2008_0005;
    cycle();
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL b2b_addr0: got %h want 0", imem_addr); end
    cycle();
    n_cmp++; if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL b2b_addr1: got %h want 4", imem_addr); end
    n_cmp++; if (if_id_pc4 !== 32'h4) begin n_bad++; $display("FAIL b2b_pc4_0: got %h want 4", if_id_pc4); end
    n_cmp++; if (if_id_imm16 !== 16'h0005) begin n_bad++; $display("FAIL b2b_imm0: got %h want 0005", if_id_imm16); end
    n_cmp++; if (if_id_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid0: got %b want 1", if_id_valid); end
    imem_rdata = 32'h2009_0003;
    cycle();
    n_cmp++; if (imem_addr !== 32'h8) begin n_bad++; $display("FAIL b2b_addr2: got %h want 8", imem_addr); end
    n_cmp++; if (if_id_pc4 !== 32'h8) begin n_bad++; $display("FAIL b2b_pc4_1: got %h want 8", if_id_pc4); end
    n_cmp++; if (if_id_imm16 !== 16'h0003) begin n_bad++; $display("FAIL b2b_imm1: got %h want 0003", if_id_imm16); end
    n_cmp++; if (if_id_instr !== 32'h2009_0003) begin n_bad++; $display("FAIL b2b_instr1: got %h want 20090003", if_id_instr); end
    imem_ack = 0;
  endtask

  task automatic test_ack_delay();
    apply_reset();
    imem_ack = 1; imem_rdata = 32'h1111_0001;
    repeat (2) cycle();
    imem_ack = 0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin
        n_bad++; $display("FAIL delay_hold_req[%0d]: got req=%b addr=%h want req=1 addr=4", i, imem_req, imem_addr);
      end
      if (i < 3) begin
        cycle();
        n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL delay_valid[%0d]: got %b want 0", i, if_id_valid); end
      end
    end
    imem_ack = 1; imem_rdata = 32'h2222_0002;
    cycle();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h2222_0002 || if_id_pc4 !== 32'h8) begin
      n_bad++; $display("FAIL delay_load: got v=%b i=%h p=%h want v=1 i=22220002 p=8", if_id_valid, if_id_instr, if_id_pc4);
    end
    n_cmp++; if (imem_addr !== 32'h8) begin n_bad++; $display("FAIL delay_next_addr: got %h want 8", imem_addr); end
    imem_ack = 0;
  endtask

  task automatic test_stall_hold();
    apply_reset();
    imem_ack = 1; imem_rdata = 32'h1234_5678;
    repeat (2) cycle();
    imem_rdata = 32'h8C02_0010; id_stall = 1;
    cycle();
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL hold_req[%0d]: got %b want 0", i, imem_req); end
      n_cmp++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h1234_5678 || if_id_pc4 !== 32'h4) begin
        n_bad++; $display("FAIL hold_frozen[%0d]: got v=%b i=%h p=%h want v=1 i=12345678 p=4", i, if_id_valid, if_id_instr, if_id_pc4);
      end
      if (i == 0) cycle();
    end
    id_stall = 0;
    cycle();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h8C02_0010 || if_id_pc4 !== 32'h8) begin
      n_bad++; $display("FAIL hold_release: got v=%b i=%h p=%h want v=1 i=8c020010 p=8", if_id_valid, if_id_instr, if_id_pc4);
    end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      n_bad++; $display("FAIL hold_no_refetch: got req=%b addr=%h want req=1 addr=8", imem_req, imem_addr);
    end
    imem_ack = 0;
  endtask

  task automatic test_branch_squash();
    apply_reset();
    imem_ack = 1; imem_rdata = 32'h0000_1111;
    repeat (5) cycle();
    // Redirect to 0x14 leaves if_id_pc4 at 0x10 with the record invalid.
    imem_ack = 0; br_take = 1; br_imm_ext = 32'h1;
    cycle();
    br_take = 0; imem_ack = 1;
    cycle();
    imem_ack = 0;
    cycle();
    n_cmp++; if (imem_addr !== 32'h14 || if_id_pc4 !== 32'h10) begin
      n_bad++; $display("FAIL br_setup: got addr=%h pc4=%h want addr=14 pc4=10", imem_addr, if_id_pc4);
    end
    br_take = 1; br_imm_ext = 32'hFFFF_FFFD;
    cycle();
    br_take = 0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      n_bad++; $display("FAIL br_wait_hold: got req=%b addr=%h want req=1 addr=14", imem_req, imem_addr);
    end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL br_valid_wait: got %b want 0", if_id_valid); end
    imem_ack = 1; imem_rdata = 32'hBADB_AD00;
    cycle();
    imem_ack = 0;
    n_cmp++; if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL br_target_addr: got %h want 4", imem_addr); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL br_dropped: got %b want 0", if_id_valid); end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    imem_ack = 1; imem_rdata = 32'h5555_0001;
    repeat (2) cycle();
    imem_ack = 0;
    cycle();
    #2 rst_n = 0;
    model_reset();
    #1;
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      n_bad++; $display("FAIL rst_wait_req: got req=%b addr=%h want req=0 addr=0", imem_req, imem_addr);
    end
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin
      n_bad++; $display("FAIL rst_wait_ifid: got v=%b i=%h p=%h want all 0", if_id_valid, if_id_instr, if_id_pc4);
    end
    imem_ack = 1; imem_rdata = 32'h6666_0002;
    cycle();
    rst_n = 1;
    cycle();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_wait_first: got req=%b addr=%h v=%b want req=1 addr=0 v=0", imem_req, imem_addr, if_id_valid);
    end
    cycle();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h6666_0002 || if_id_pc4 !== 32'h4) begin
      n_bad++; $display("FAIL rst_wait_load: got v=%b i=%h p=%h want v=1 i=66660002 p=4", if_id_valid, if_id_instr, if_id_pc4);
    end
    imem_ack = 0;
  endtask

  task automatic test_wrap();
    apply_reset();
    imem_ack = 1; imem_rdata = 32'h0000_0001;
    repeat (2) cycle();
    br_take = 1; br_imm_ext = 32'hFFFF_FFFE;
    cycle();
    br_take = 0;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC || if_id_valid !== 1'b0) begin
      n_bad++; $display("FAIL wrap_target: got addr=%h v=%b want addr=fffffffc v=0", imem_addr, if_id_valid);
    end
    imem_rdata = 32'h3C01_ABCD;
    cycle();
    imem_ack = 0;
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h0 || if_id_imm16 !== 16'hABCD) begin
      n_bad++; $display("FAIL wrap_load: got v=%b p=%h imm=%h want v=1 p=0 imm=abcd", if_id_valid, if_id_pc4, if_id_imm16);
    end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++; if (fetch_count !== 32'd2 || squash_count !== 16'd1) begin
      n_bad++; $display("FAIL wrap_counts: got f=%0d s=%0d want f=2 s=1", fetch_count, squash_count);
    end
`endif
  endtask

  task automatic test_random();
    int off;
    apply_reset();
    for (int c = 0; c < 3000 && n_bad < 20; c++) begin
      imem_ack   = ($urandom_range(0, 2) != 0);
      id_stall   = ($urandom_range(0, 3) == 0);
      br_take    = ($urandom_range(0, 9) == 0);
      off        = int'($urandom_range(0, 31)) - 16;
      br_imm_ext = off;
      imem_rdata = $urandom();
      cycle();
      if ($urandom_range(0, 249) == 0) begin
        #1 rst_n = 0;
        model_reset();
        #1 rst_n = 1;
      end
      n_cmp++; if (imem_req !== (m_started && !m_hold_full) || imem_addr !== m_pc) begin
        n_bad++; $display("FAIL rnd_req[%0d]: got req=%b addr=%h want req=%b addr=%h", c, imem_req, imem_addr, m_started && !m_hold_full, m_pc);
      end
      n_cmp++; if (if_id_valid !== m_valid || if_id_instr !== m_instr || if_id_pc4 !== m_pc4) begin
        n_bad++; $display("FAIL rnd_ifid[%0d]: got v=%b i=%h p=%h want v=%b i=%h p=%h", c, if_id_valid, if_id_instr, if_id_pc4, m_valid, m_instr, m_pc4);
      end
      n_cmp++; if (if_id_imm16 !== m_instr[15:0]) begin
        n_bad++; $display("FAIL rnd_imm16[%0d]: got %h want %h", c, if_id_imm16, m_instr[15:0]);
      end
`ifdef FETCH_PERF_CNT_EN
      n_cmp++; if (fetch_count !== m_fetch_cnt || squash_count !== m_squash_cnt) begin
        n_bad++; $display("FAIL rnd_counts[%0d]: got f=%0d s=%0d want f=%0d s=%0d", c, fetch_count, squash_count, m_fetch_cnt, m_squash_cnt);
      end
`endif
    end
    imem_ack = 0; id_stall = 0; br_take = 0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ack_delay();
    test_stall_hold();
    test_branch_squash();
    test_reset_mid_wait();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
